// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter
//   Shares one 5-bit LFSR random source between N_REQ requesters. Requesters
//   are served in round-robin order. Each draw steps the LFSR through a
//   one-cycle advance strobe. Draws above MAX_VAL are rejected and redrawn.
//   After MAX_RETRY rejected draws the delivered value is forced to MAX_VAL.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   req_i        per-requester level request, held high until granted
//   gnt_o        one-hot, one-cycle grant pulse; rand_o is valid with it
//   rand_o       delivered random value (0..MAX_VAL), held between grants
//   busy_o       high whenever the arbiter is not idle
//   lfsr_next_o  advance strobe to the LFSR
//   lfsr_rand_i  LFSR output; reflects a step on the edge after lfsr_next_o
module lfsr_rand_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_VAL   = 23,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [4:0]       rand_o,
    output logic             busy_o,
    output logic             lfsr_next_o,
    input  logic [4:0]       lfsr_rand_i
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        SAMPLE,
        GRANT
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   cand;
    logic [2:0]      retry;
    logic            found;
    int unsigned     idx;

    // Rotating-priority search: first set request strictly after ptr,
    // wrapping modulo N_REQ, so the last winner has lowest priority.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = PW'(idx);
            if (!found && req_i[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            gnt_o       <= '0;
            rand_o      <= '0;
            busy_o      <= 1'b0;
            lfsr_next_o <= 1'b0;
            ptr         <= PW'(N_REQ - 1);
            retry       <= '0;
            winner      <= '0;
        end else begin
            // Both strobes are single-cycle; states that want them set them.
            gnt_o       <= '0;
            lfsr_next_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        winner      <= pick;
                        retry       <= '0;
                        state       <= STEP;
                        lfsr_next_o <= 1'b1;
                        busy_o      <= 1'b1;
                    end
                end
                STEP: begin
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    if (!req_i[winner]) begin
                        // Winner withdrew: no grant, pointer keeps its value.
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (lfsr_rand_i <= 5'(MAX_VAL)) begin
                        rand_o <= lfsr_rand_i;
                        gnt_o  <= N_REQ'(1) << winner;
                        state  <= GRANT;
                    end else if (retry == 3'(MAX_RETRY - 1)) begin
                        rand_o <= 5'(MAX_VAL);
                        gnt_o  <= N_REQ'(1) << winner;
                        state  <= GRANT;
                    end else begin
                        retry       <= retry + 3'd1;
                        state       <= STEP;
                        lfsr_next_o <= 1'b1;
                    end
                end
                GRANT: begin
                    ptr    <= winner;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// tb_lfsr_rand_arbiter
//   Bench for lfsr_rand_arbiter. An 8-bit LFSR stand-in (or a random source)
//   answers the advance strobe; a transaction-level model predicts winner,
//   delivered value, draw count and grant latency.
module tb_lfsr_rand_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned MAXV = 23;
    localparam int unsigned MAXR = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [4:0] rnd;
    logic       busy;
    logic       lnext;
    logic [4:0] lrand;

    int compared   = 0;
    int mismatched = 0;

    // Random source: 8-bit LFSR seeded 8'h01, or $urandom draws.
    logic [7:0] lfsr8   = 8'h01;
    logic [4:0] rnd_val = 5'd0;
    bit         use_rand = 1'b0;
    logic [4:0] drawn[$];

    int unsigned ptr_m;

    lfsr_rand_arbiter #(
        .N_REQ    (N),
        .MAX_VAL  (MAXV),
        .MAX_RETRY(MAXR)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .gnt_o      (gnt),
        .rand_o     (rnd),
        .busy_o     (busy),
        .lfsr_next_o(lnext),
        .lfsr_rand_i(lrand)
    );

    always #5 clk = ~clk;

    assign lrand = use_rand ? rnd_val : lfsr8[4:0];

    always @(posedge clk) begin
        logic [7:0] nxt;
        logic [4:0] v;
        if (lnext) begin
            if (use_rand) begin
                v = 5'($urandom_range(0, 31));
                rnd_val <= v;
            end else begin
                nxt = {lfsr8[6:0], ~(lfsr8[7] ^ lfsr8[5])};
                lfsr8 <= nxt;
                v = nxt[4:0];
            end
            drawn.push_back(v);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model_winner(input logic [3:0] pat, input int unsigned p);
        int unsigned w;
        bit          hit;
        w   = p;
        hit = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!hit && pat[(p + k) % N]) begin
                w   = (p + k) % N;
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    // One request transaction starting with the arbiter idle. Returns the
    // grant cycle (cycle 0 = request applied) and the delivered value.
    task automatic txn(input logic [3:0] pat, input bit release_win,
                       output int got_c, output logic [4:0] got_r);
        int unsigned exp_w;
        int          npulse;
        int          first;
        int          n_m;
        bit          done;
        logic [4:0]  v_m;
        logic [3:0]  exp_g;
        exp_w  = model_winner(pat, ptr_m);
        exp_g  = 4'(1 << exp_w);
        drawn.delete();
        req    = pat;
        npulse = 0;
        first  = -1;
        got_c  = -1;
        for (int c = 1; c <= 20 && got_c < 0; c++) begin
            @(posedge clk);
            #1;
            if (lnext) begin
                npulse++;
                if (first < 0) first = c;
            end
            if (gnt != 4'b0) got_c = c;
        end
        got_r = rnd;
        check("grant_seen", 32'(got_c > 0), 32'd1);
        n_m  = 0;
        done = 1'b0;
        v_m  = 5'bx;
        foreach (drawn[i]) begin
            if (!done) begin
                n_m++;
                if (drawn[i] <= 5'(MAXV)) begin
                    v_m  = drawn[i];
                    done = 1'b1;
                end else if (n_m == int'(MAXR)) begin
                    v_m  = 5'(MAXV);
                    done = 1'b1;
                end
            end
        end
        check("gnt_winner", 32'(gnt), 32'(exp_g));
        check("rand_value", 32'(rnd), 32'(v_m));
        check("grant_latency", 32'(got_c), 32'(1 + 2 * n_m));
        check("step_pulses", 32'(npulse), 32'(n_m));
        check("first_step_cycle", 32'(first), 32'd1);
        ptr_m = exp_w;
        if (release_win) req[exp_w] = 1'b0;
        @(posedge clk);
        #1;
        check("busy_after_grant", 32'(busy), 32'd0);
        check("gnt_after_grant", 32'(gnt), 32'd0);
        check("rand_held", 32'(rnd), 32'(v_m));
    endtask

    initial begin
        int         c;
        logic [4:0] r;
        logic [3:0] pat;

        // Reset values
        rst_n = 1'b0;
        req   = 4'b0;
        ptr_m = N - 1;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rand", 32'(rnd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_next", 32'(lnext), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Seeded LFSR: single requester, four transactions 3, 7, 15, forced 23
        txn(4'b0001, 1'b1, c, r);
        check("seed_first_rand", 32'(r), 32'd3);
        check("seed_first_cycle", 32'(c), 32'd3);
        txn(4'b0001, 1'b1, c, r);
        check("seed_second_rand", 32'(r), 32'd7);
        txn(4'b0001, 1'b1, c, r);
        check("seed_third_rand", 32'(r), 32'd15);
        txn(4'b0001, 1'b1, c, r);
        check("forced_rand", 32'(r), 32'd23);
        check("forced_cycle", 32'(c), 32'd7);

        // 0101 held with pointer at 0: 2, 0, 2, 0
        for (int t = 0; t < 4; t++) begin
            txn(4'b0101, 1'b0, c, r);
        end
        req = 4'b0;
        check("ptr_after_0101", 32'(ptr_m), 32'd0);

        // Winner withdraws during STEP: no grant, pointer unchanged
        req = 4'b0100;
        @(posedge clk);
        #1;
        check("drop_step_strobe", 32'(lnext), 32'd1);
        req = 4'b0000;
        for (int k = 2; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check("drop_no_gnt", 32'(gnt), 32'd0);
            if (k >= 3) check("drop_idle", 32'(busy), 32'd0);
        end
        txn(4'b1111, 1'b0, c, r);
        req = 4'b0;

        // Asynchronous reset mid-SAMPLE
        req = 4'b1000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("sample_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_rand", 32'(rnd), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_next", 32'(lnext), 32'd0);
        req = 4'b0;
        ptr_m = N - 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All requesting after reset: 0, 1, 2, 3, 0
        for (int t = 0; t < 5; t++) begin
            txn(4'b1111, 1'b0, c, r);
            check("rr_order", 32'(ptr_m), 32'(t % 4));
        end
        req = 4'b0;

        // Random request patterns and random draws
        use_rand = 1'b1;
        for (int t = 0; t < 24; t++) begin
            pat = 4'($urandom_range(1, 15));
            txn(pat, 1'b0, c, r);
        end
        req = 4'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
- Shares one 5-bit LFSR random source between N_REQ requesters, e.g. the game's spawners and colour pickers.
- Grants requesters in round-robin order and steps the LFSR once per draw through its advance strobe.
- Rejects draws above MAX_VAL and delivers an in-range value to the granted requester with a one-cycle grant pulse.
- Sits between the LFSR instance and the game-logic blocks that consume random values.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_VAL, 23, largest accepted random value (0..31); draws > MAX_VAL are rejected
MAX_RETRY, 3, rejected draws allowed before the value is forced to MAX_VAL (1..7)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
req_i  input  N_REQ  per-requester level request; held high until its grant
gnt_o  output  N_REQ  one-hot one-cycle grant pulse; rand_o valid in the same cycle
rand_o  output  5  delivered random value, 0..MAX_VAL
busy_o  output  1  high whenever the FSM is not in IDLE
lfsr_next_o  output  1  advance strobe to the LFSR's next_i
lfsr_rand_i  input  5  LFSR rand_o; updates on the clock edge after lfsr_next_o=1

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - FSM goes to IDLE.
  - gnt_o=0, rand_o=0, busy_o=0, lfsr_next_o=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has highest priority first.
  - Retry counter = 0, winner register = 0.
  - Reset mid-transaction aborts it with no grant. The LFSR keeps any step already taken.
- FSM states: IDLE, STEP, SAMPLE, GRANT.
- IDLE:
  - If req_i != 0, choose the winner: first set bit searching from pointer+1 upward, wrapping modulo N_REQ.
  - Register the winner, clear the retry counter, go to STEP.
  - If req_i == 0, stay in IDLE.
- STEP: lfsr_next_o=1 for exactly this cycle; go to SAMPLE. lfsr_next_o is 0 in every other state.
- SAMPLE: read lfsr_rand_i, which already reflects the step.
  - If the winner's req_i bit is 0: abort to IDLE with no grant; pointer unchanged.
  - Else if lfsr_rand_i <= MAX_VAL: register rand_o = lfsr_rand_i, go to GRANT.
  - Else if retry counter == MAX_RETRY-1: register rand_o = MAX_VAL, go to GRANT.
  - Else: increment the retry counter, go to STEP.
- GRANT:
  - gnt_o[winner]=1 for this cycle only; pointer = winner; go to IDLE.
  - No new arbitration happens in GRANT, so at most one grant is issued per 4 cycles.
- rand_o holds its last delivered value between grants. Consumers sample it only while their gnt_o bit is high.
- Latency:
  - A request seen in IDLE at cycle 0 gives STEP at cycle 1, SAMPLE at 2 and grant at 3.
  - Each rejected draw adds 2 cycles.
  - Worst case is 1 + 2*MAX_RETRY cycles to GRANT.
- Requests that arrive during busy_o=1 wait; there is no queuing beyond the level-held req_i.
- Fairness: a requester held high is granted within N_REQ transactions.
- Simultaneous requests: exactly one winner, chosen by the rotating priority. Others stay pending.
- gnt_o is never multi-hot, and is never asserted to a requester whose req_i was low in SAMPLE.

Test Plan:
- LFSR seed 8'h01 (out of reset), req_i=4'b0001 held → lfsr_next_o high in cycle 1, gnt_o=4'b0001 in cycle 3 with rand_o=3, busy_o low in cycle 4.
- Four back-to-back single-requester transactions from seed 8'h01 → rand_o = 3, 7, 15, then the 4th draw (31) is rejected, the next draw (31) is rejected, the next (30) is rejected; after MAX_RETRY=3 rejections rand_o=23, and that grant arrives 4 cycles later than an unrejected one.
- req_i=4'b1111 held continuously → grant order 0,1,2,3,0,1,…; gnt_o always one-hot; exactly one lfsr_next_o pulse per accepted first-try draw.
- req_i=4'b0101 with pointer=0 after one grant → next grant goes to requester 2, then 0; requesters 1 and 3 are never granted.
- Winner drops req_i during STEP → no gnt_o pulse, FSM returns to IDLE, pointer unchanged, and the next grant goes to the same position rule.
- rst_ni pulsed low asynchronously mid-SAMPLE → all outputs 0 immediately without waiting for a clock edge; after release, requester 0 wins first.
